// File: rtl/life_row_engine_if.sv
// life_row_engine_if: bundle between the frame-buffer/display side and the row engine
// Ports (slave = engine side):
//   in : noise, ruleBirth[8:0], ruleSurvive[8:0], drawRequest, reading, readRow[WIDTH-1:0],
//        displayActive, row[ROW_BITS-1:0], column[COL_BITS-1:0]
//   out: drawRow[WIDTH-1:0], writeRow[WIDTH-1:0], writeValid, busy, overrun
interface life_row_engine_if #(
    parameter int WIDTH    = 640,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
);
    logic                noise;
    logic [8:0]          ruleBirth;
    logic [8:0]          ruleSurvive;
    logic                drawRequest;
    logic                reading;
    logic [WIDTH-1:0]    readRow;
    logic                displayActive;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] column;
    logic [WIDTH-1:0]    drawRow;
    logic [WIDTH-1:0]    writeRow;
    logic                writeValid;
    logic                busy;
    logic                overrun;
    modport slave (
        input  noise, ruleBirth, ruleSurvive, drawRequest, reading, readRow, displayActive, row, column,
        output drawRow, writeRow, writeValid, busy, overrun
    );
    modport master (
        output noise, ruleBirth, ruleSurvive, drawRequest, reading, readRow, displayActive, row, column,
        input  drawRow, writeRow, writeValid, busy, overrun
    );
endinterface

// File: rtl/life_row_engine.sv
// life_row_engine: next-generation Life-like row calculator over a three-row sliding window
// Ports:
//   clkDiv : pixel-rate clock, all state on its rising edge
//   rst    : synchronous active-high reset
//   io_bus : life_row_engine_if.slave (window feed, rules, draw/noise in; drawRow/writeRow/status out)
module life_row_engine #(
    parameter int WIDTH    = 640,
    parameter int LANES    = 32,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9,
    parameter int WRAP     = 1
) (
    input logic clkDiv,
    input logic rst,
    life_row_engine_if.slave io_bus
);
    localparam int CHUNKS = WIDTH / LANES;
    localparam int KB     = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam int EB     = $clog2(WIDTH + 2);
    localparam int SB     = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           r_state, w_next_state;
    logic             r_reading_d, r_write_valid, r_overrun;
    logic             w_load, w_busy, w_unused;
    logic [1:0]       r_cnt;
    logic [KB-1:0]    r_k;
    logic [WIDTH-1:0] r_above, r_cur, r_below, r_shadow, r_write_row, r_mask, r_draw_row;
    logic [WIDTH-1:0] w_draw_bit;
    logic [WIDTH+1:0] w_ext_a, w_ext_c, w_ext_b;
    logic [LANES+1:0] w_win_a, w_win_c, w_win_b;
    logic [LANES-1:0] w_life, w_chunk;
    logic [EB-1:0]    w_ebase;
    logic [SB-1:0]    w_sbase;

    // Row padded with one column on each side: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
    function automatic logic [WIDTH+1:0] f_ext(input logic [WIDTH-1:0] r);
        return {WRAP != 0 ? r[0] : 1'b0, r, WRAP != 0 ? r[WIDTH-1] : 1'b0};
    endfunction

    // row and displayActive are informational only.
    assign w_unused   = ^{io_bus.row, io_bus.displayActive};
    assign w_load     = io_bus.reading & ~r_reading_d;
    assign w_draw_bit = (io_bus.drawRequest && 32'(io_bus.column) < WIDTH) ? WIDTH'(1) << io_bus.column : '0;

    assign w_ext_a = f_ext(r_above);
    assign w_ext_c = f_ext(r_cur);
    assign w_ext_b = f_ext(r_below);
    assign w_ebase = EB'(r_k * LANES);
    assign w_sbase = SB'(r_k * LANES);
    assign w_win_a = w_ext_a[w_ebase +: LANES + 2];
    assign w_win_c = w_ext_c[w_ebase +: LANES + 2];
    assign w_win_b = w_ext_b[w_ebase +: LANES + 2];

    // Lane l covers column k*LANES+l, which sits at window bit l+1.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_n;
        assign w_n = 4'(w_win_a[l]) + 4'(w_win_a[l+1]) + 4'(w_win_a[l+2])
                   + 4'(w_win_c[l])                    + 4'(w_win_c[l+2])
                   + 4'(w_win_b[l]) + 4'(w_win_b[l+1]) + 4'(w_win_b[l+2]);
        assign w_life[l] = w_win_c[l+1] ? io_bus.ruleSurvive[w_n] : io_bus.ruleBirth[w_n];
    end

    assign w_chunk = w_life | LANES'(io_bus.noise);

    always_ff @(posedge clkDiv)
        r_state <= rst ? IDLE : w_next_state;

    // A load completing the third window row (or arriving with it already full) starts a compute.
    always_comb
        w_next_state = r_state == IDLE    ? ((w_load && r_cnt >= 2'd2) ? COMPUTE : IDLE) :
                       r_state == COMPUTE ? ((r_k == KB'(CHUNKS - 1)) ? DONE : COMPUTE) :
                                            IDLE;

    always_comb
        w_busy = r_state != IDLE;

    always_ff @(posedge clkDiv) begin
        if (rst) begin
            r_reading_d   <= 1'b0;
            r_write_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_cnt         <= '0;
            r_k           <= '0;
            r_above       <= '0;
            r_cur         <= '0;
            r_below       <= '0;
            r_shadow      <= '0;
            r_write_row   <= '0;
            r_mask        <= '0;
            r_draw_row    <= '0;
        end else begin
            r_reading_d   <= io_bus.reading;
            r_write_valid <= r_state == DONE;
            r_draw_row    <= r_cur | r_mask;
            r_k           <= r_state == COMPUTE ? r_k + KB'(1) : '0;
            if (w_load && !w_busy) begin
                r_above <= r_cur;
                r_cur   <= r_below;
                r_below <= io_bus.readRow;
                r_cnt   <= r_cnt == 2'd3 ? 2'd3 : r_cnt + 2'd1;
            end
            if (w_load && w_busy)
                r_overrun <= 1'b1;
            if (r_state == COMPUTE)
                r_shadow[w_sbase +: LANES] <= w_chunk;
            // The mask is consumed in DONE; a request on that edge starts the next row's mask.
            if (r_state == DONE) begin
                r_write_row <= r_shadow | r_mask;
                r_mask      <= w_draw_bit;
            end else
                r_mask <= r_mask | w_draw_bit;
        end
    end

    assign io_bus.drawRow    = r_draw_row;
    assign io_bus.writeRow   = r_write_row;
    assign io_bus.writeValid = r_write_valid;
    assign io_bus.busy       = w_busy;
    assign io_bus.overrun    = r_overrun;
endmodule

// File: tb/tb_life_row_engine.sv
// tb_life_row_engine: scoreboard bench for life_row_engine (WRAP=1 and WRAP=0 instances in lockstep)
module tb_life_row_engine;
    localparam int W = 640;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] w1;
        logic [W-1:0] w0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    life_row_engine_if bus();
    life_row_engine_if bus0();

    life_row_engine #(.WRAP(1)) dut  (.clkDiv(clk), .rst(rst), .io_bus(bus));
    life_row_engine #(.WRAP(0)) dut0 (.clkDiv(clk), .rst(rst), .io_bus(bus0));

    assign bus0.noise         = bus.noise;
    assign bus0.ruleBirth     = bus.ruleBirth;
    assign bus0.ruleSurvive   = bus.ruleSurvive;
    assign bus0.drawRequest   = bus.drawRequest;
    assign bus0.reading       = bus.reading;
    assign bus0.readRow       = bus.readRow;
    assign bus0.displayActive = bus.displayActive;
    assign bus0.row           = bus.row;
    assign bus0.column        = bus.column;

    function automatic logic [W-1:0] b(input int i);
        return W'(1) << i;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic load(input logic [W-1:0] r);
        bus.readRow = r;
        bus.reading = 1'b1;
        step(1);
        bus.reading = 1'b0;
        step(1);
    endtask

    // Called right after the compute-triggering load: that load was at edge cyc-1, result due 21 edges later.
    task automatic expect_wr(input logic [W-1:0] w1, input logic [W-1:0] w0);
        exp_t e;
        e.cyc = cyc + 20;
        e.w1  = w1;
        e.w0  = w0;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy && t < 40) begin
            step(1);
            t++;
        end
        n_cmp++;
        if (bus.busy) begin
            n_bad++;
            $display("FAIL idle_timeout: busy got 1 want 0 after 40 cycles");
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.writeValid || bus0.writeValid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_writeValid: got pulse at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                chk("writeValid_cycle", W'(cyc), W'(e.cyc));
                chk("writeValid_both", W'({bus.writeValid, bus0.writeValid}), W'(2'b11));
                chk("writeRow_wrap1", bus.writeRow, e.w1);
                chk("writeRow_wrap0", bus0.writeRow, e.w0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] m;
        bus.noise         = 1'b0;
        bus.ruleBirth     = 9'h008;
        bus.ruleSurvive   = 9'h00C;
        bus.drawRequest   = 1'b0;
        bus.reading       = 1'b0;
        bus.readRow       = '0;
        bus.displayActive = 1'b1;
        bus.row           = '0;
        bus.column        = '0;
        do_reset();
        chk("rst_writeRow", bus.writeRow, '0);
        chk("rst_drawRow", bus.drawRow, '0);
        chk1("rst_writeValid", bus.writeValid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);

        load('0);
        chk1("busy_after_1_load", bus.busy, 1'b0);
        load(b(4) | b(5) | b(6));
        chk1("busy_after_2_loads", bus.busy, 1'b0);
        load('0);
        expect_wr(b(5), b(5));
        chk1("busy_after_3_loads", bus.busy, 1'b1);
        chk("drawRow_blinker", bus.drawRow, b(4) | b(5) | b(6));
        wait_idle();
        step(1);

        do_reset();
        bus.readRow = '0;
        bus.reading = 1'b1;
        step(3);
        bus.reading = 1'b0;
        step(1);
        load(b(0) | b(1) | b(639));
        chk1("held_reading_single_load", bus.busy, 1'b0);
        load('0);
        expect_wr(b(0), '0);
        chk("drawRow_edge_row", bus.drawRow, b(0) | b(1) | b(639));
        wait_idle();
        step(1);

        do_reset();
        load('0);
        load(b(4) | b(5) | b(6));
        load('0);
        expect_wr(b(5), b(5));
        step(3);
        load('1);
        chk1("overrun_set", bus.overrun, 1'b1);
        chk("overrun_window_kept", bus.drawRow, b(4) | b(5) | b(6));
        wait_idle();
        step(2);
        chk1("overrun_sticky", bus.overrun, 1'b1);

        do_reset();
        bus.column = 10'd639;
        bus.drawRequest = 1'b1;
        step(1);
        bus.column = 10'd700;
        step(1);
        bus.drawRequest = 1'b0;
        step(1);
        chk("drawRow_mask_639", bus.drawRow, b(639));
        load('0);
        load('0);
        load('0);
        expect_wr(b(639), b(639));
        step(19);
        bus.column = 10'd100;
        bus.drawRequest = 1'b1;
        step(1);
        bus.drawRequest = 1'b0;
        wait_idle();
        step(1);
        chk("draw_in_done_kept", bus.drawRow, b(100));
        load('0);
        expect_wr(b(100), b(100));
        wait_idle();
        step(2);
        chk("mask_cleared", bus.drawRow, '0);

        do_reset();
        bus.noise = 1'b1;
        load('0);
        load('0);
        load('0);
        step(9);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("abort_writeRow", bus.writeRow, '0);
        chk("abort_drawRow", bus.drawRow, '0);
        chk1("abort_writeValid", bus.writeValid, 1'b0);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_overrun", bus.overrun, 1'b0);
        step(1);
        load('0);
        load('0);
        chk1("abort_no_compute_2_loads", bus.busy, 1'b0);
        load('0);
        m = '0;
        for (int i = 0; i < W / 32; i++) m = m | b(i * 32);
        expect_wr(m, m);
        chk1("abort_compute_3rd_load", bus.busy, 1'b1);
        wait_idle();
        step(2);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_writeValid: got %0d outstanding want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
